gpio_dbus_arbiter: RTL and testbench

GPIO_DBUS_ARBITER -- requirements
Module: gpio_dbus_arbiter

---
 rtl/gpio_dbus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_gpio_dbus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_dbus_arbiter.sv
// gpio_dbus_arbiter: shares one GPIO data-bus slave between two requesters.
// Two-state FSM (IDLE/BUSY) with a wait counter that ends stalled transfers
// with a zero-data ack and raises a sticky timeout flag.
// Optional feature: define GPIO_ARB_RR_EN for round-robin tie breaking;
// without it requester 0 always wins ties (fixed priority).

package gpio_dbus_arbiter_pkg;

    // Request from a bus master towards a peripheral
    typedef struct packed {
        logic        req;
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] w_data;
    } type_dbus2peri_s;

    // Response from a peripheral back to a bus master
    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;

endpackage

module gpio_dbus_arbiter
    import gpio_dbus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  type_dbus2peri_s m0_dbus_i,
    input  logic            m0_sel_i,
    output type_peri2dbus_s m0_dbus_o,
    input  type_dbus2peri_s m1_dbus_i,
    input  logic            m1_sel_i,
    output type_peri2dbus_s m1_dbus_o,
    output type_dbus2peri_s gpio_dbus_o,
    output logic            gpio_sel_o,
    input  type_peri2dbus_s gpio_dbus_i,
    output logic            timeout_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Counter value on the last BUSY cycle allowed before a forced ack
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            owner;
    logic [7:0]      wait_cnt;

    logic            m0_pending;
    logic            m1_pending;
    logic            any_pending;
    logic            grant_m1;
    logic            owner_pending;
    logic            owner_sel;
    logic            timeout_hit;
    type_dbus2peri_s owner_dbus;
    type_peri2dbus_s owner_resp;

`ifdef GPIO_ARB_RR_EN
    logic            rr_ptr;
`endif

    assign m0_pending  = m0_dbus_i.req & m0_sel_i;
    assign m1_pending  = m1_dbus_i.req & m1_sel_i;
    assign any_pending = m0_pending | m1_pending;

`ifdef GPIO_ARB_RR_EN
    // Ties go to whichever requester the pointer currently favours
    assign grant_m1 = m1_pending & (~m0_pending | rr_ptr);
`else
    // Requester 0 always wins a tie
    assign grant_m1 = m1_pending & ~m0_pending;
`endif

    assign owner_dbus    = owner ? m1_dbus_i  : m0_dbus_i;
    assign owner_sel     = owner ? m1_sel_i   : m0_sel_i;
    assign owner_pending = owner ? m1_pending : m0_pending;
    assign timeout_hit   = (wait_cnt == TIMEOUT_LAST);

    // Forward the owner's request and build its response; everything is zero outside BUSY
    always_comb begin
        gpio_dbus_o = '0;
        gpio_sel_o  = 1'b0;
        owner_resp  = '0;
        if (state == BUSY) begin
            gpio_dbus_o = owner_dbus;
            gpio_sel_o  = owner_sel;
            if (owner_pending) begin
                if (gpio_dbus_i.ack) begin
                    owner_resp.ack    = 1'b1;
                    owner_resp.r_data = gpio_dbus_i.r_data;
                end else if (timeout_hit) begin
                    owner_resp.ack    = 1'b1;
                    owner_resp.r_data = 32'h0;
                end else begin
                    owner_resp.ack    = 1'b0;
                    owner_resp.r_data = gpio_dbus_i.r_data;
                end
            end
        end
    end

    // Steer the response to the owner only; the other requester sees zeros
    always_comb begin
        m0_dbus_o = '0;
        m1_dbus_o = '0;
        if (state == BUSY) begin
            if (owner) begin
                m1_dbus_o = owner_resp;
            end else begin
                m0_dbus_o = owner_resp;
            end
        end
    end

    // Arbitration FSM: grant in IDLE, wait for ack, timeout or abort in BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            wait_cnt  <= 8'd0;
            timeout_o <= 1'b0;
`ifdef GPIO_ARB_RR_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        owner    <= grant_m1;
                        wait_cnt <= 8'd0;
                        state    <= BUSY;
`ifdef GPIO_ARB_RR_EN
                        rr_ptr   <= ~grant_m1;
`endif
                    end
                end
                BUSY: begin
                    if (!owner_pending) begin
                        wait_cnt <= 8'd0;
                        state    <= IDLE;
                    end else if (gpio_dbus_i.ack) begin
                        wait_cnt <= 8'd0;
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        wait_cnt  <= 8'd0;
                        timeout_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_dbus_arbiter.sv
// tb_gpio_dbus_arbiter: directed bench for gpio_dbus_arbiter with a
// one-cycle-ack slave model and an ack scoreboard checked by a monitor.
// Tie-break expectations follow GPIO_ARB_RR_EN when it is defined.

module tb_gpio_dbus_arbiter;
    import gpio_dbus_arbiter_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        master;
        logic [31:0] rdata;
        int          cycle;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    type_dbus2peri_s m0_in;
    type_dbus2peri_s m1_in;
    logic            m0_sel;
    logic            m1_sel;
    type_peri2dbus_s m0_out;
    type_peri2dbus_s m1_out;
    type_dbus2peri_s gpio_out;
    logic            gpio_sel;
    type_peri2dbus_s gpio_in;
    logic            timeout;

    logic            slave_en;
    logic            slave_ack;
    logic [31:0]     slave_rdata;
    logic            force_ack;
    logic [31:0]     force_rdata;

    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    exp_t            exp_q[$];

    gpio_dbus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_dbus_i   (m0_in),
        .m0_sel_i    (m0_sel),
        .m0_dbus_o   (m0_out),
        .m1_dbus_i   (m1_in),
        .m1_sel_i    (m1_sel),
        .m1_dbus_o   (m1_out),
        .gpio_dbus_o (gpio_out),
        .gpio_sel_o  (gpio_sel),
        .gpio_dbus_i (gpio_in),
        .timeout_o   (timeout)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle number, advanced on every rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: registered single-cycle ack, read data derived from the address
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            slave_ack   <= 1'b0;
            slave_rdata <= 32'h0;
        end else if (slave_en && gpio_sel && gpio_out.req && !slave_ack) begin
            slave_ack   <= 1'b1;
            slave_rdata <= {gpio_out.addr[15:0], 16'hBEEF};
        end else begin
            slave_ack   <= 1'b0;
            slave_rdata <= 32'h0;
        end
    end

    // Slave response seen by the arbiter, with an injectable stray ack
    always_comb begin
        gpio_in.ack    = slave_ack | force_ack;
        gpio_in.r_data = slave_rdata | force_rdata;
    end

    task automatic check_output(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic m, input logic req, input logic w_en,
                                  input logic [31:0] addr, input logic [31:0] data);
        type_dbus2peri_s v;
        v.req    = req;
        v.w_en   = w_en;
        v.addr   = addr;
        v.w_data = data;
        if (m) begin
            m1_in  = v;
            m1_sel = req;
        end else begin
            m0_in  = v;
            m0_sel = req;
        end
    endtask

    task automatic push_exp(input logic m, input logic [31:0] rdata, input int cycle);
        exp_t e;
        e.master = m;
        e.rdata  = rdata;
        e.cycle  = cycle;
        exp_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_gpio_sel"}, 66'(gpio_sel), 66'(0));
        check_output({tag, "_gpio_dbus"}, 66'(gpio_out), 66'(0));
        check_output({tag, "_m0_resp"}, 66'(m0_out), 66'(0));
        check_output({tag, "_m1_resp"}, 66'(m1_out), 66'(0));
    endtask

    // Monitor: every ack the DUT presents is popped from the scoreboard and compared
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
                    check_output("ack_missing_cycle", 66'(cyc), 66'(exp_q[0].cycle));
                    void'(exp_q.pop_front());
                end
                for (int m = 0; m < 2; m++) begin
                    type_peri2dbus_s r;
                    r = (m == 1) ? m1_out : m0_out;
                    if (r.ack === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            check_output($sformatf("unexpected_ack_m%0d", m), 66'(r.ack), 66'(0));
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check_output("ack_master", 66'(m), 66'(e.master));
                            check_output($sformatf("ack_rdata_m%0d", m), 66'(r.r_data), 66'(e.rdata));
                            check_output($sformatf("ack_cycle_m%0d", m), 66'(cyc), 66'(e.cycle));
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        type_dbus2peri_s fwd;
        int              n;
        int              m1_drop;

        rst         = 1'b1;
        m0_in       = '0;
        m1_in       = '0;
        m0_sel      = 1'b0;
        m1_sel      = 1'b0;
        slave_en    = 1'b1;
        force_ack   = 1'b0;
        force_rdata = 32'h0;

        // Reset state
        step(3);
        check_idle_outputs("reset");
        check_output("reset_timeout", 66'(timeout), 66'(0));
        rst = 1'b0;
        step(2);

        // Single write from m0, expected ack two cycles after the request
        n = cyc;
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_A5A5);
        push_exp(1'b0, 32'h0004_BEEF, n + 2);
        #1;
        check_output("idle_pending_sel", 66'(gpio_sel), 66'(0));
        step(1);
        fwd = '{req: 1'b1, w_en: 1'b1, addr: 32'h0000_0004, w_data: 32'h0000_A5A5};
        check_output("fwd_m0_write", 66'(gpio_out), 66'(fwd));
        check_output("fwd_m0_sel", 66'(gpio_sel), 66'(1));
        check_output("m1_resp_quiet", 66'(m1_out), 66'(0));
        step(1);
        check_output("m1_resp_quiet_ack", 66'(m1_out), 66'(0));
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(2);

        // m1 aborts before ack, then a stray ack arrives while IDLE
        slave_en = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
        step(1);
        check_output("abort_fwd_addr", 66'(gpio_out.addr), 66'(32'h30));
        step(1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_output("abort_no_ack", 66'(m1_out.ack), 66'(0));
        step(1);
        force_ack   = 1'b1;
        force_rdata = 32'h1111_2222;
        #1;
        check_idle_outputs("stray_ack");
        step(1);
        force_ack   = 1'b0;
        force_rdata = 32'h0;
        step(2);

        // Slave never acks: forced ack with zero data on the 16th BUSY cycle
        n = cyc;
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        push_exp(1'b0, 32'h0, n + TIMEOUT);
        step(TIMEOUT - 1);
        check_output("timeout_before", 66'(timeout), 66'(0));
        step(2);
        check_output("timeout_set", 66'(timeout), 66'(1));
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(4);
        check_output("timeout_sticky", 66'(timeout), 66'(1));

        // Reset asserted in the second BUSY cycle clears everything at once
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'h0);
        step(2);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        check_output("mid_reset_timeout", 66'(timeout), 66'(0));
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1);
        rst      = 1'b0;
        slave_en = 1'b1;
        step(1);

        // Normal m1 write after reset
        n = cyc;
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0060, 32'h0000_CAFE);
        push_exp(1'b1, 32'h0060_BEEF, n + 2);
        step(1);
        fwd = '{req: 1'b1, w_en: 1'b1, addr: 32'h0000_0060, w_data: 32'h0000_CAFE};
        check_output("fwd_m1_write", 66'(gpio_out), 66'(fwd));
        check_output("m0_resp_quiet", 66'(m0_out), 66'(0));
        step(2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(2);

        // Both request reads in the same cycle; m0 keeps requesting back-to-back
        n = cyc;
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
`ifdef GPIO_ARB_RR_EN
        push_exp(1'b0, 32'h0010_BEEF, n + 2);
        push_exp(1'b1, 32'h0020_BEEF, n + 5);
        push_exp(1'b0, 32'h0010_BEEF, n + 8);
        m1_drop = 6;
`else
        push_exp(1'b0, 32'h0010_BEEF, n + 2);
        push_exp(1'b0, 32'h0010_BEEF, n + 5);
        push_exp(1'b0, 32'h0010_BEEF, n + 8);
        push_exp(1'b1, 32'h0020_BEEF, n + 11);
        m1_drop = 12;
`endif
        for (int k = 1; k <= 13; k++) begin
            step(1);
            if (k == 9) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == m1_drop) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        step(3);

        @(negedge clk);
        #1;
        check_output("queue_empty", 66'(exp_q.size()), 66'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
